// File: rtl/uart_debug_loader.sv
// uart_debug_loader: UART command sequencer for program load and run/step.
// Ports:
//   clk, reset        clock, async active-high reset
//   i_rx_ready/data   level-style byte valid and received byte
//   i_cpu_halted      core idle/halted, gates run and step
//   o_imem_we/addr    one-cycle word write strobe and word address
//   o_imem_data       assembled instruction, held outside the write
//   o_load_done       pulse when the terminating word is written
//   o_run, o_step     one-cycle pipeline control strobes
//   o_error           one-cycle protocol error pulse
//   o_busy            high while a load is in progress
module uart_debug_loader #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [31:0] HALT_WORD      = 32'hFFFF_FFFF,
  parameter logic [7:0]  CMD_LOAD       = 8'h4C,
  parameter logic [7:0]  CMD_RUN        = 8'h43,
  parameter logic [7:0]  CMD_STEP       = 8'h53
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_rx_ready,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_cpu_halted,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [31:0]           o_imem_data,
  output logic                  o_load_done,
  output logic                  o_run,
  output logic                  o_step,
  output logic                  o_error,
  output logic                  o_busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_PRE = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE
  } state_t;

  state_t                state;
  logic                  rx_ready_d;
  logic                  rx_ev;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            byte_idx;
  logic [23:0]           shreg;
  logic [31:0]           word;
  logic [TW-1:0]         tmo_cnt;
  logic                  program_loaded;
  logic                  ovf;
  logic                  cmd_ok;

  assign rx_ev  = i_rx_ready & ~rx_ready_d;
  assign word   = {shreg, i_rx_data};
  assign cmd_ok = program_loaded & i_cpu_halted;
  assign o_busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      rx_ready_d     <= 1'b1;
      addr           <= '0;
      byte_idx       <= '0;
      shreg          <= '0;
      tmo_cnt        <= '0;
      program_loaded <= 1'b0;
      ovf            <= 1'b0;
      o_imem_we      <= 1'b0;
      o_imem_addr    <= '0;
      o_imem_data    <= '0;
      o_load_done    <= 1'b0;
      o_run          <= 1'b0;
      o_step         <= 1'b0;
      o_error        <= 1'b0;
    end else begin
      rx_ready_d  <= i_rx_ready;
      o_imem_we   <= 1'b0;
      o_load_done <= 1'b0;
      o_run       <= 1'b0;
      o_step      <= 1'b0;
      o_error     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (rx_ev) begin
            // ~o_error keeps a timeout error followed at once
            // by a bad command from merging into a 2-cycle pulse
            unique case (1'b1)
              (i_rx_data == CMD_LOAD): begin
                addr           <= '0;
                byte_idx       <= '0;
                tmo_cnt        <= '0;
                ovf            <= 1'b0;
                program_loaded <= 1'b0;
                state          <= S_LOAD;
              end
              (i_rx_data == CMD_RUN): begin
                if (cmd_ok) o_run <= 1'b1;
                else o_error <= ~o_error;
              end
              (i_rx_data == CMD_STEP): begin
                if (cmd_ok) o_step <= 1'b1;
                else o_error <= ~o_error;
              end
              default: o_error <= ~o_error;
            endcase
          end
        end
        S_LOAD: begin
          if (rx_ev) begin
            tmo_cnt  <= '0;
            shreg    <= word[23:0];
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              if (ovf) begin
                o_error <= 1'b1;
                state   <= S_IDLE;
              end else begin
                o_imem_we   <= 1'b1;
                o_imem_addr <= addr;
                o_imem_data <= word;
                o_load_done <= (word == HALT_WORD);
                state       <= S_WRITE;
              end
            end
          end else if (tmo_cnt == TMO_PRE) begin
            tmo_cnt <= '0;
            o_error <= 1'b1;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_WRITE: begin
          // a byte landing in the write cycle starts the next word
          if (rx_ev) begin
            tmo_cnt  <= '0;
            shreg    <= word[23:0];
            byte_idx <= byte_idx + 2'd1;
          end
          if (o_imem_data == HALT_WORD) begin
            program_loaded <= 1'b1;
            state          <= S_IDLE;
          end else begin
            addr  <= addr + ADDR_WIDTH'(1);
            state <= S_LOAD;
            if (addr == ADDR_MAX) ovf <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_debug_loader.sv
// tb_uart_debug_loader: random and directed byte streams
// compared against a transaction-level loader model.
module tb_uart_debug_loader;

  localparam int TMO   = 50;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [7:0] C_L = 8'h4C;
  localparam logic [7:0] C_C = 8'h43;
  localparam logic [7:0] C_S = 8'h53;

  localparam int K_WE   = 1;
  localparam int K_DONE = 2;
  localparam int K_RUN  = 3;
  localparam int K_STEP = 4;
  localparam int K_ERR  = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_rx_ready = 1'b1;
  logic [7:0]    i_rx_data = 8'h55;
  logic          i_cpu_halted = 1'b0;
  logic          o_imem_we;
  logic [AW-1:0] o_imem_addr;
  logic [31:0]   o_imem_data;
  logic          o_load_done;
  logic          o_run;
  logic          o_step;
  logic          o_error;
  logic          o_busy;

  uart_debug_loader #(
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_rx_ready(i_rx_ready),
    .i_rx_data(i_rx_data),
    .i_cpu_halted(i_cpu_halted),
    .o_imem_we(o_imem_we),
    .o_imem_addr(o_imem_addr),
    .o_imem_data(o_imem_data),
    .o_load_done(o_load_done),
    .o_run(o_run),
    .o_step(o_step),
    .o_error(o_error),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [79:0] got,
                     input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [79:0] ev(input int k, input int a,
                                     input logic [31:0] d,
                                     input int c);
    return {8'(k), 8'(a), d, 32'(c)};
  endfunction

  logic [79:0] obsq[$];
  logic [79:0] expq[$];

  // observed pulses, tagged with the clock edge that raised them
  logic [3:0] prev_p = '0;
  logic [3:0] cur_p;
  always @(negedge clk) begin
    if (reset) begin
      prev_p = '0;
    end else begin
      cur_p = {o_load_done, o_run, o_step, o_error};
      if (o_imem_we)
        obsq.push_back(ev(K_WE, int'(o_imem_addr), o_imem_data, cyc));
      if (o_load_done) obsq.push_back(ev(K_DONE, 0, 0, cyc));
      if (o_run) obsq.push_back(ev(K_RUN, 0, 0, cyc));
      if (o_step) obsq.push_back(ev(K_STEP, 0, 0, cyc));
      if (o_error) obsq.push_back(ev(K_ERR, 0, 0, cyc));
      if (cur_p != 4'd0)
        chk("pulse_1cyc", 80'(prev_p & cur_p), 80'(0));
      prev_p = cur_p;
    end
  end

  // loader model: byte queue, word address, flags
  bit         m_loading;
  bit         m_loaded;
  bit         m_ovf;
  int         m_addr;
  int         m_deadline;
  logic [7:0] m_buf[$];

  function automatic void model_reset();
    m_loading = 0;
    m_loaded  = 0;
    m_ovf     = 0;
    m_addr    = 0;
    m_buf.delete();
  endfunction

  function automatic void model_timeout();
    expq.push_back(ev(K_ERR, 0, 0, m_deadline));
    m_loading = 0;
    m_buf.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b,
                                     input logic halted,
                                     input int e);
    logic [31:0] w;
    if (!m_loading) begin
      if (b == C_L) begin
        m_loading  = 1;
        m_loaded   = 0;
        m_ovf      = 0;
        m_addr     = 0;
        m_buf.delete();
        m_deadline = e + TMO - 1;
      end else if (b == C_C && m_loaded && halted) begin
        expq.push_back(ev(K_RUN, 0, 0, e));
      end else if (b == C_S && m_loaded && halted) begin
        expq.push_back(ev(K_STEP, 0, 0, e));
      end else begin
        expq.push_back(ev(K_ERR, 0, 0, e));
      end
    end else begin
      m_buf.push_back(b);
      m_deadline = e + TMO - 1;
      if (m_buf.size() == 4) begin
        w = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
        m_buf.delete();
        if (m_ovf) begin
          expq.push_back(ev(K_ERR, 0, 0, e));
          m_loading = 0;
        end else begin
          expq.push_back(ev(K_WE, m_addr, w, e));
          if (w == HALT) begin
            expq.push_back(ev(K_DONE, 0, 0, e));
            m_loading = 0;
            m_loaded  = 1;
          end else begin
            // one write cycle passes before the idle count resumes
            m_deadline = e + TMO;
            if (m_addr == DEPTH - 1) m_ovf = 1;
            m_addr = (m_addr + 1) % DEPTH;
          end
        end
      end
    end
  endfunction

  task automatic send(input logic [7:0] b, input logic halted,
                      input int hold, input int gap);
    int e;
    @(negedge clk);
    e = cyc + 1;
    if (m_loading && e == m_deadline + 1) begin
      @(negedge clk);
      e = cyc + 1;
    end
    if (m_loading && e > m_deadline) model_timeout();
    i_cpu_halted = halted;
    i_rx_data    = b;
    i_rx_ready   = 1'b1;
    model_byte(b, halted, e);
    repeat (hold) @(negedge clk);
    i_rx_ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[8*i +: 8], 1'b0, 2, 2);
  endtask

  task automatic compare(input string tag);
    int n;
    repeat (2) @(negedge clk);
    if (m_loading && cyc >= m_deadline) model_timeout();
    chk({tag, "_n"}, 80'(obsq.size()), 80'(expq.size()));
    n = (obsq.size() < expq.size()) ? obsq.size() : expq.size();
    for (int i = 0; i < n; i++) chk(tag, obsq[i], expq[i]);
    chk({tag, "_busy"}, 80'(o_busy), 80'(m_loading));
    obsq.delete();
    expq.delete();
  endtask

  task automatic flush(input string tag);
    repeat (TMO + 4) @(negedge clk);
    compare(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    i_rx_ready = 1'b0;
    #1;
    chk(tag, 80'({o_imem_we, o_imem_addr, o_imem_data, o_load_done,
                  o_run, o_step, o_error, o_busy}), 80'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    obsq.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0]  b;
    logic [31:0] w;
    int          r;
    int          nw;
    model_reset();

    // stale ready high across reset release: no event
    repeat (3) @(negedge clk);
    chk("reset_out", 80'({o_imem_we, o_imem_addr, o_imem_data,
                          o_load_done, o_run, o_step, o_error,
                          o_busy}), 80'(0));
    reset = 1'b0;
    repeat (5) @(negedge clk);
    i_rx_ready = 1'b0;
    compare("stale");

    // long ready level: one step command, no program -> error
    send(C_S, 1'b1, 200, 3);
    compare("hold_s");

    send(C_L, 1'b0, 2, 2);
    send_word(32'h2001_0005);
    send_word(HALT);
    compare("load");

    send(C_S, 1'b1, 2, 2);
    send(C_C, 1'b0, 2, 2);
    compare("cmd");

    // long level on load command, then timeout
    send(C_L, 1'b0, 200, 3);
    compare("hold_l");

    send(C_L, 1'b0, 2, 2);
    send(8'h12, 1'b0, 2, 2);
    send(8'h34, 1'b0, 2, 2);
    flush("timeout");

    send(C_L, 1'b0, 1, 1);
    for (int i = 0; i < 5; i++) send_word(32'h1000_0000 + i);
    compare("ovf");

    send(C_L, 1'b0, 2, 2);
    send_word(32'hABCD_0123);
    send(8'h77, 1'b0, 2, 2);
    send(8'h66, 1'b0, 2, 2);
    compare("pre_rst");
    do_reset("mid_rst");
    send(C_L, 1'b0, 2, 2);
    send_word(32'h0BAD_F00D);
    send_word(HALT);
    compare("post_rst");
    send(C_C, 1'b1, 2, 2);
    compare("run");

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        send(C_L, 1'b0, $urandom_range(1, 4), $urandom_range(1, 5));
        nw = $urandom_range(1, 6);
        for (int k = 0; k < nw; k++) begin
          w = $urandom;
          if (k == nw - 1 && $urandom_range(0, 3) != 0) w = HALT;
          for (int j = 3; j >= 0; j--) begin
            if (r == 3 && k == 0 && j == 1) repeat (60) @(negedge clk);
            send(w[8*j +: 8], 1'($urandom),
                 $urandom_range(1, 5), $urandom_range(1, 6));
          end
        end
      end else if (r <= 6) begin
        b = ($urandom_range(0, 1) != 0) ? C_C : C_S;
        send(b, 1'($urandom), $urandom_range(1, 5), $urandom_range(1, 4));
      end else if (r <= 8) begin
        send(8'($urandom), 1'($urandom), $urandom_range(1, 5),
             $urandom_range(1, 4));
      end
      flush("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
